// File: rtl/baud_tick_gen_if.sv
// -----------------------------------------------------------------------------
// baud_tick_gen_if
// Control/status bundle between a UART controller and the baud tick generator.
//
// Signals:
//   en        count enable
//   div_load  1-cycle strobe that latches div_in (and frac_in)
//   div_in    new divisor, clk cycles per oversampling tick (0 is treated as 1)
//   frac_in   fractional divisor part in sixteenths (only with BAUD_FRAC_EN)
//   tick_os   1-cycle oversampling pulse
//   tick_bit  1-cycle bit pulse, every OVERSAMPLE-th tick_os
//   div_cur   divisor currently in use
//
// Modports: master (controller side), slave (generator side).
// Optional feature macro: BAUD_FRAC_EN adds frac_in.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface baud_tick_gen_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic             div_load;
    logic [DIV_W-1:0] div_in;
`ifdef BAUD_FRAC_EN
    logic [3:0]       frac_in;
`endif
    logic             tick_os;
    logic             tick_bit;
    logic [DIV_W-1:0] div_cur;

`ifdef BAUD_FRAC_EN
    modport master (
        output en, div_load, div_in, frac_in,
        input  tick_os, tick_bit, div_cur
    );
    modport slave (
        input  en, div_load, div_in, frac_in,
        output tick_os, tick_bit, div_cur
    );
`else
    modport master (
        output en, div_load, div_in,
        input  tick_os, tick_bit, div_cur
    );
    modport slave (
        input  en, div_load, div_in,
        output tick_os, tick_bit, div_cur
    );
`endif
endinterface

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Baud-rate tick generator for the UART datapath. Divides clk by a runtime
// loadable divisor to produce a 1-cycle oversampling tick (tick_os) and a
// 1-cycle bit tick (tick_bit) on every OVERSAMPLE-th oversampling tick.
//
// Parameters:
//   DIV_W        width of the divisor register and clock counter
//   DEFAULT_DIV  divisor loaded at reset (1 .. 2^DIV_W-1)
//   OVERSAMPLE   tick_os pulses per tick_bit (>= 2)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    baud_tick_gen_if.slave: en, div_load, div_in, [frac_in] in;
//          tick_os, tick_bit, div_cur out
//
// Optional feature macro: BAUD_FRAC_EN enables fractional division. The
// fractional part accumulates in sixteenths; each accumulator carry stretches
// the following period by one clock.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module baud_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 163,
    parameter int OVERSAMPLE  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    baud_tick_gen_if.slave bus
);

    localparam int               OS_W      = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W:0]   ONE_EXT   = (DIV_W + 1)'(1);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] cnt;
    logic [OS_W-1:0]  os_cnt;
    logic             tick_os_q;
    logic             tick_bit_q;
    logic             stretch;
    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W:0]   period;
    logic             period_end;

    // A zero divisor would never terminate a period, so it is clamped to 1.
    assign div_clamped = (bus.div_in == '0) ? MIN_DIV : bus.div_in;

    // Period is computed one bit wider so a stretched maximum divisor
    // (2^DIV_W) still compares correctly; cnt itself never exceeds div_reg.
    assign period     = {1'b0, div_reg} + {{DIV_W{1'b0}}, stretch};
    assign period_end = ({1'b0, cnt} == (period - ONE_EXT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg    <= RESET_DIV;
            cnt        <= '0;
            os_cnt     <= '0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else if (bus.div_load) begin
            div_reg    <= div_clamped;
            cnt        <= '0;
            os_cnt     <= '0;
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end else if (bus.en) begin
            if (period_end) begin
                cnt       <= '0;
                tick_os_q <= 1'b1;
                if (os_cnt == OS_LAST) begin
                    os_cnt     <= '0;
                    tick_bit_q <= 1'b1;
                end else begin
                    os_cnt     <= os_cnt + 1'b1;
                    tick_bit_q <= 1'b0;
                end
            end else begin
                cnt        <= cnt + 1'b1;
                tick_os_q  <= 1'b0;
                tick_bit_q <= 1'b0;
            end
        end else begin
            // Disabled: counters hold so the interrupted period resumes.
            tick_os_q  <= 1'b0;
            tick_bit_q <= 1'b0;
        end
    end

`ifdef BAUD_FRAC_EN
    logic [3:0] frac_reg;
    logic [3:0] acc;
    logic [4:0] acc_sum;
    logic       tick_evt;

    assign acc_sum  = {1'b0, acc} + {1'b0, frac_reg};
    assign tick_evt = bus.en & period_end & ~bus.div_load;

    // The carry out of the sixteenths accumulator decides whether the period
    // that starts after this tick is one clock longer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frac_reg <= '0;
            acc      <= '0;
            stretch  <= 1'b0;
        end else if (bus.div_load) begin
            frac_reg <= bus.frac_in;
            acc      <= '0;
            stretch  <= 1'b0;
        end else if (tick_evt) begin
            acc      <= acc_sum[3:0];
            stretch  <= acc_sum[4];
        end
    end
`else
    assign stretch = 1'b0;
`endif

    assign bus.tick_os  = tick_os_q;
    assign bus.tick_bit = tick_bit_q;
    assign bus.div_cur  = div_reg;

endmodule

// File: tb/tb_baud_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_tick_gen
// Self-checking bench for baud_tick_gen. A behavioural model tracks enabled
// clocks into the current period and the number of ticks since the last load;
// the length of period n is derived in closed form from the fractional part.
// Every driven cycle is compared against the model, on top of a vector table
// and hand-written sequences for latency, pause/resume and async reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_baud_tick_gen;

    localparam int DIV_W       = 16;
    localparam int DEFAULT_DIV = 163;
    localparam int OVERSAMPLE  = 16;
`ifdef BAUD_FRAC_EN
    localparam bit FRAC_BUILD = 1'b1;
`else
    localparam bit FRAC_BUILD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   edgeNum = 0;

    // model state
    int mDiv, mFrac, mDone, mN;
    bit expOs, expBit;

    baud_tick_gen_if #(.DIV_W(DIV_W)) bus ();

    baud_tick_gen #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             en;
        bit             load;
        logic [15:0]    div;
        logic [3:0]     frac;
        int             cycles;
        int             expOsCount;
        int             expBitCount;
        int             expCur;
    } vec_t;

    vec_t vecs[8];

    // Length of the n-th period after a load: period 0 is never stretched,
    // later ones gain a clock whenever n*frac/16 crosses an integer.
    function automatic int periodLen(int n);
        if (n == 0) return mDiv;
        return mDiv + ((n * mFrac) / 16 - ((n - 1) * mFrac) / 16);
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " tick_os"},  32'(bus.tick_os),  32'(expOs));
        checkValue({tag, " tick_bit"}, 32'(bus.tick_bit), 32'(expBit));
        checkValue({tag, " div_cur"},  32'(bus.div_cur),  32'(mDiv));
    endtask

    task automatic modelReset();
        mDiv   = DEFAULT_DIV;
        mFrac  = 0;
        mDone  = 0;
        mN     = 0;
        expOs  = 1'b0;
        expBit = 1'b0;
    endtask

    task automatic modelStep(input bit e, input bit l, input int d, input int f);
        if (l) begin
            mDiv   = (d == 0) ? 1 : d;
            mFrac  = FRAC_BUILD ? f : 0;
            mDone  = 0;
            mN     = 0;
            expOs  = 1'b0;
            expBit = 1'b0;
        end else if (e) begin
            mDone++;
            if (mDone == periodLen(mN)) begin
                mDone  = 0;
                mN++;
                expOs  = 1'b1;
                expBit = ((mN % OVERSAMPLE) == 0);
            end else begin
                expOs  = 1'b0;
                expBit = 1'b0;
            end
        end else begin
            expOs  = 1'b0;
            expBit = 1'b0;
        end
    endtask

    // Drive one cycle on the falling edge, advance the model on the rising
    // edge and compare shortly after it.
    task automatic applyStimulus(input bit e, input bit l, input logic [DIV_W-1:0] d,
                                 input logic [3:0] f, input string tag);
        @(negedge clk);
        bus.en       = e;
        bus.div_load = l;
        bus.div_in   = d;
`ifdef BAUD_FRAC_EN
        bus.frac_in  = f;
`endif
        @(posedge clk);
        edgeNum++;
        modelStep(e, l, int'(d), int'(f));
        #1;
        checkOutput(tag);
    endtask

    // Hold reset a few cycles, check the reset state, then release just after
    // a rising edge so the next rising edge is edge 1.
    task automatic doReset();
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.div_load = 1'b0;
        bus.div_in   = '0;
`ifdef BAUD_FRAC_EN
        bus.frac_in  = '0;
`endif
        repeat (3) @(negedge clk);
        modelReset();
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        edgeNum = 0;
    endtask

    initial begin
        int tickEdges[$];
        int firstBit;
        int prevTick;
        int resumeCount;
        int osCount;
        int bitCount;
        bit found;

        vecs[0] = '{1'b1, 1'b1, 16'd5,  4'd0, 80,  16, 1, 5};
        vecs[1] = '{1'b1, 1'b1, 16'd0,  4'd0, 32,  32, 2, 1};
        vecs[2] = '{1'b1, 1'b1, 16'd3,  4'd0, 48,  16, 1, 3};
        vecs[3] = '{1'b0, 1'b0, 16'd3,  4'd0, 20,  0,  0, 3};
        vecs[4] = '{1'b0, 1'b1, 16'd7,  4'd0, 10,  0,  0, 7};
        vecs[5] = '{1'b1, 1'b0, 16'd7,  4'd0, 112, 16, 1, 7};
        vecs[6] = '{1'b1, 1'b1, 16'd2,  4'd0, 33,  16, 1, 2};
        vecs[7] = '{1'b1, 1'b1, 16'd10, 4'd4, 164, 16, 1, 10};

        // Default divisor: ticks on edges 163, 326, 489; first bit on 2608.
        doReset();
        firstBit = -1;
        for (int i = 0; i < 2620; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 4'd0, "default");
            if (bus.tick_os === 1'b1) tickEdges.push_back(edgeNum);
            if (bus.tick_bit === 1'b1 && firstBit < 0) firstBit = edgeNum;
        end
        checkValue("default tick count", 32'(tickEdges.size()), 32'd16);
        checkValue("first tick edge",  32'((tickEdges.size() > 0) ? tickEdges[0] : -1), 32'd163);
        checkValue("second tick edge", 32'((tickEdges.size() > 1) ? tickEdges[1] : -1), 32'd326);
        checkValue("third tick edge",  32'((tickEdges.size() > 2) ? tickEdges[2] : -1), 32'd489);
        checkValue("first bit edge", 32'(firstBit), 32'd2608);

        // Pause at cnt = 100 for 7 cycles; next tick 63 enabled edges later.
        doReset();
        repeat (163) applyStimulus(1'b1, 1'b0, '0, 4'd0, "pause lead");
        checkValue("pause lead tick", 32'(bus.tick_os), 32'd1);
        prevTick = edgeNum;
        repeat (100) applyStimulus(1'b1, 1'b0, '0, 4'd0, "pause pre");
        repeat (7)   applyStimulus(1'b0, 1'b0, '0, 4'd0, "paused");
        resumeCount = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 4'd0, "resume");
            resumeCount++;
            if (bus.tick_os === 1'b1) found = 1'b1;
        end
        checkValue("resume tick found", 32'(found), 32'd1);
        checkValue("resume enabled edges", 32'(resumeCount), 32'd63);
        checkValue("resume wall clocks", 32'(edgeNum - prevTick), 32'd170);

        // Load while disabled, then async reset mid-cycle while a tick is high.
        applyStimulus(1'b0, 1'b1, 16'd9, 4'd0, "load idle");
        repeat (9) applyStimulus(1'b1, 1'b0, '0, 4'd0, "div9");
        checkValue("div9 tick before reset", 32'(bus.tick_os), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async reset tick_os",  32'(bus.tick_os),  32'd0);
        checkValue("async reset tick_bit", 32'(bus.tick_bit), 32'd0);
        checkValue("async reset div_cur",  32'(bus.div_cur),  32'(DEFAULT_DIV));

        // Vector table.
        doReset();
        foreach (vecs[v]) begin
            if (vecs[v].load)
                applyStimulus(vecs[v].en, 1'b1, vecs[v].div, vecs[v].frac, "vec load");
            osCount  = 0;
            bitCount = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                applyStimulus(vecs[v].en, 1'b0, vecs[v].div, vecs[v].frac, "vec run");
                if (bus.tick_os === 1'b1)  osCount++;
                if (bus.tick_bit === 1'b1) bitCount++;
            end
            checkValue($sformatf("vec%0d tick_os count", v),  32'(osCount),  32'(vecs[v].expOsCount));
            checkValue($sformatf("vec%0d tick_bit count", v), 32'(bitCount), 32'(vecs[v].expBitCount));
            checkValue($sformatf("vec%0d div_cur", v), 32'(bus.div_cur), 32'(vecs[v].expCur));
        end

`ifdef BAUD_FRAC_EN
        // Fractional 10 + 4/16: of periods 1..16, four are 11 clocks, sum 164.
        begin
            int lens[$];
            int last;
            int longCount;
            int sum;
            applyStimulus(1'b1, 1'b1, 16'd10, 4'd4, "frac load");
            last = edgeNum;
            for (int i = 0; i < 400 && lens.size() < 17; i++) begin
                applyStimulus(1'b1, 1'b0, '0, 4'd0, "frac run");
                if (bus.tick_os === 1'b1) begin
                    lens.push_back(edgeNum - last);
                    last = edgeNum;
                end
            end
            checkValue("frac periods seen", 32'(lens.size()), 32'd17);
            longCount = 0;
            sum = 0;
            for (int i = 1; i < lens.size(); i++) begin
                sum += lens[i];
                if (lens[i] == 11) longCount++;
            end
            checkValue("frac stretched periods", 32'(longCount), 32'd4);
            checkValue("frac total clocks", 32'(sum), 32'd164);
        end
`endif

        // Randomised traffic against the model.
        doReset();
        for (int i = 0; i < 4000; i++) begin
            bit e;
            bit l;
            e = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 299) == 0);
            applyStimulus(e, l, DIV_W'($urandom_range(0, 6)), 4'($urandom_range(0, 15)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART datapath. It divides the system clock by a runtime-loadable divisor to produce a 1-cycle oversampling tick (`tick_os`) for the receiver sampler, and a 1-cycle bit tick (`tick_bit`) every `OVERSAMPLE` oversampling ticks for the transmitter. It supersedes the fixed divide-by-163 generator and adds enable, divisor reload, bit-rate tick and optional fractional division.

## Interface
- `DIV_W`, 16, width of the divisor register and clock counter.
- `DEFAULT_DIV`, 163, divisor loaded at reset; must satisfy 1 ≤ `DEFAULT_DIV` < 2^`DIV_W`.
- `OVERSAMPLE`, 16, number of `tick_os` pulses per `tick_bit`; must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  count enable; when low, counters hold and both ticks are 0.
- `div_load`  in  1  1-cycle strobe that latches `div_in`.
- `div_in`  in  `DIV_W`  new divisor, in clk cycles per `tick_os`.
- `frac_in`  in  4  fractional divisor part in sixteenths; sampled on `div_load`. Present only when `BAUD_FRAC_EN` is defined.
- `tick_os`  out  1  registered 1-cycle oversampling pulse.
- `tick_bit`  out  1  registered 1-cycle bit pulse, coincident with every `OVERSAMPLE`-th `tick_os`.
- `div_cur`  out  `DIV_W`  divisor currently in use.

## Operation
- Registers: `div_reg` (`DIV_W`), clock counter `cnt` (`DIV_W`), oversample counter `os_cnt` (width clog2(`OVERSAMPLE`)), and, with `BAUD_FRAC_EN`, `frac_reg` (4), `acc` (4) and `stretch` (1).
- Reset (asynchronous, `rst_n` = 0): `div_reg` = `DEFAULT_DIV`, `cnt` = 0, `os_cnt` = 0, `tick_os` = 0, `tick_bit` = 0, `div_cur` = `DEFAULT_DIV`, `frac_reg` = 0, `acc` = 0, `stretch` = 0.
- Priority per cycle: `div_load` > `en` > hold.
- `div_load` = 1: `div_reg` ← `div_in`, with 0 clamped to 1; `cnt` ← 0; `os_cnt` ← 0; `acc` ← 0; `stretch` ← 0; both ticks 0 in the next cycle. This holds regardless of `en`.
- `en` = 1, no load: let period = `div_reg` + `stretch`.
  - If `cnt` == period − 1: `cnt` ← 0 and `tick_os` ← 1.
  - Otherwise: `cnt` ← `cnt` + 1 and `tick_os` ← 0.
- On each `tick_os` event:
  - `os_cnt` wraps at `OVERSAMPLE` − 1 → 0; at that wrap, `tick_bit` ← 1.
  - With `BAUD_FRAC_EN`: {carry, `acc`} ← `acc` + `frac_reg`, and `stretch` ← carry for the next period.
- `en` = 0: `cnt`, `os_cnt`, `acc` and `stretch` hold; ticks ← 0. Resuming continues the interrupted period; there is no restart.
- Divisor 1: `tick_os` is high every enabled cycle and `tick_bit` every `OVERSAMPLE` cycles.
- The counter never exceeds `div_reg`. Overflow is impossible because period ≤ 2^`DIV_W` − 1 + 1, and `cnt` only reaches period − 1.

## Timing
- First `tick_os` after reset release with `en` held high is on the clock edge numbered `DEFAULT_DIV` (edges counted from 1 after release). Default: 163rd edge.
- Steady-state `tick_os` period is exactly `div_reg` clocks (plus 1 on stretched periods).
- `tick_bit` period is `OVERSAMPLE` × `div_reg` clocks. First `tick_bit` occurs with the `OVERSAMPLE`-th `tick_os`.
- Reload latency: `div_cur` updates one edge after `div_load`. The first tick at the new rate is `div_in` enabled edges after the load edge.
- Both outputs are glitch-free registers, high for exactly one `clk` cycle, never back-to-back unless the divisor is 1.
- Reset asserted mid-period clears outputs immediately (asynchronous). There is no partial pulse on release.

## Configuration
- `BAUD_FRAC_EN` defined: `frac_in`, `frac_reg`, `acc` and `stretch` are present. The average `tick_os` period is `div_reg` + `frac_reg`/16 clocks, spread as evenly as the accumulator allows: `frac_reg` stretched periods per 16.
- `BAUD_FRAC_EN` undefined: the `frac_in` port is absent, `stretch` is tied to 0, and the period is exactly `div_reg`.

## Test plan
- Reset, `en` = 1, defaults → `tick_os` on edges 163, 326, 489; `tick_bit` first on edge 2608 (16×163); `div_cur` = 163.
- `div_load` with `div_in` = 5 mid-period → `div_cur` = 5 next edge; ticks every 5 clocks starting 5 edges after load; `tick_bit` every 80.
- `div_in` = 0 load → `div_cur` = 1; `tick_os` high every enabled cycle; `tick_bit` every 16 cycles.
- `en` dropped for 7 cycles at `cnt` = 100 (div 163) → no ticks while low; next `tick_os` lands 63 enabled edges after resume (170 wall clocks after the previous tick).
- `div_load` and `en` = 0 in the same cycle, then `rst_n` pulsed low mid-period → load still applied; outputs 0 immediately on reset; `div_cur` returns to 163.
- `BAUD_FRAC_EN`, `div_in` = 10, `frac_in` = 4 → over 16 `tick_os` periods, exactly 4 are 11 clocks and 12 are 10 clocks; total 164 clocks.
